// File: rtl/miner_pkg.sv
// Shared definitions for the miner job path (job sequencer and nonce generators).
//   HDR_WORDS   : 32-bit words per block header (fixed 640-bit header)
//   CNT_W       : width of a header word index
//   HDR_PAD     : SHA-256 padding tail appended by the generators
//   job_state_e : job sequencer state encoding
//   cnt_next()  : header word index increment, wrapping after the last word
package miner_pkg;

    localparam int unsigned HDR_WORDS = 20;
    localparam int unsigned CNT_W     = $clog2(HDR_WORDS);

    localparam logic [63:0] HDR_PAD = 64'h8000000000000280;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitAck,
        StStart,
        StStream,
        StRun,
        StStop,
        StDone
    } job_state_e;

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(HDR_WORDS - 1)) ? '0 : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/miner_job_ctrl_hdr_buffer.sv
// Local copy of one block header: shift-in on load, indexed read-out on stream.
//   clk, rst_n : clock, asynchronous active-low reset (clears words and index)
//   shift_i    : shift data_i in at the top; the first word shifted ends up as word 0
//   data_i     : word to shift in
//   adv_i      : advance the read index without shifting
//   cnt_o      : shared word index, 0..HDR_WORDS-1, wraps to 0 after the last word
//   last_o     : index is at the last header word
//   word_o     : buffered word selected by the index
module hdr_buffer
    import miner_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_i,
    input  logic [31:0]      data_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic [31:0]      word_o
);

    logic [31:0]      words_q [HDR_WORDS];
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(HDR_WORDS); i++) begin
                words_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (shift_i) begin
                for (int i = 0; i < int'(HDR_WORDS) - 1; i++) begin
                    words_q[i] <= words_q[i+1];
                end
                words_q[HDR_WORDS-1] <= data_i;
            end
            if (shift_i || adv_i) begin
                cnt_q <= cnt_next(cnt_q);
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(HDR_WORDS - 1));
    assign word_o = words_q[cnt_q];

endmodule

// File: rtl/miner_job_ctrl.sv
// Job sequencer in front of the nonce-generator array: loads one header from the
// block-header FIFO, starts all generators, streams the header, then waits for
// completion or stops them on host stop / golden nonce found.
//   clk, rst_n            : clock, asynchronous active-low reset
//   host_start_i/stop_i   : one-cycle host pulses (start ignored while busy)
//   nonce_size_in_i       : per-generator nonce slice, captured at job start
//   found_i               : golden nonce found pulse
//   bh_fifo_*             : first-word-fall-through header FIFO (re is combinational)
//   gen_start_o/stop_o    : broadcast start pulse / stop level
//   gen_block_header_o    : header word bus, 0 outside streaming
//   gen_nonce_size_o      : captured nonce slice size
//   gen_stop_ack_i        : per-generator idle flags
//   busy_o, job_done_o, job_aborted_o, job_count_o : host-facing status
module miner_job_ctrl
    import miner_pkg::*;
#(
    parameter int unsigned NUM_GEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               host_start_i,
    input  logic               host_stop_i,
    input  logic [31:0]        nonce_size_in_i,
    input  logic               found_i,
    input  logic [31:0]        bh_fifo_dout_i,
    input  logic               bh_fifo_empty_i,
    output logic               bh_fifo_re_o,
    output logic               gen_start_o,
    output logic               gen_stop_o,
    output logic [31:0]        gen_block_header_o,
    output logic [31:0]        gen_nonce_size_o,
    input  logic [NUM_GEN-1:0] gen_stop_ack_i,
    output logic               busy_o,
    output logic               job_done_o,
    output logic               job_aborted_o,
    output logic [31:0]        job_count_o
);

    job_state_e       state_q;
    logic             abort_pend_q;
    logic             gen_start_q;
    logic             gen_stop_q;
    logic             busy_q;
    logic             job_done_q;
    logic             job_aborted_q;
    logic [31:0]      hdr_q;
    logic [31:0]      nonce_q;
    logic [31:0]      job_count_q;

    logic             all_ack;
    logic             buf_shift;
    logic             buf_adv;
    logic             buf_last;
    logic [CNT_W-1:0] buf_cnt;
    logic [31:0]      buf_word;

    assign all_ack   = &gen_stop_ack_i;
    assign buf_shift = (state_q == StLoad) && !bh_fifo_empty_i;

    // START fetches word 0; STREAM prefetches word k+1 while word k is on the bus.
    // The index wraps to 0 after word 19 is fetched, which marks the final STREAM cycle.
    assign buf_adv = (state_q == StStart) || ((state_q == StStream) && (buf_cnt != '0));

    hdr_buffer u_hdr_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_i (buf_shift),
        .data_i  (bh_fifo_dout_i),
        .adv_i   (buf_adv),
        .cnt_o   (buf_cnt),
        .last_o  (buf_last),
        .word_o  (buf_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            abort_pend_q  <= 1'b0;
            gen_start_q   <= 1'b0;
            gen_stop_q    <= 1'b0;
            busy_q        <= 1'b0;
            job_done_q    <= 1'b0;
            job_aborted_q <= 1'b0;
            hdr_q         <= '0;
            nonce_q       <= '0;
            job_count_q   <= '0;
        end else begin
            gen_start_q <= 1'b0;
            job_done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (host_start_i) begin
                        state_q       <= StLoad;
                        busy_q        <= 1'b1;
                        nonce_q       <= nonce_size_in_i;
                        job_aborted_q <= 1'b0;
                    end
                end
                StLoad: begin
                    if (host_stop_i) begin
                        abort_pend_q <= 1'b1;
                    end
                    // An aborted load still drains the whole header to keep the FIFO aligned.
                    if (buf_shift && buf_last) begin
                        if (abort_pend_q || host_stop_i) begin
                            state_q       <= StDone;
                            job_done_q    <= 1'b1;
                            job_aborted_q <= 1'b1;
                            job_count_q   <= job_count_q + 32'd1;
                        end else begin
                            state_q <= StWaitAck;
                        end
                    end
                end
                StWaitAck: begin
                    if (all_ack) begin
                        state_q     <= StStart;
                        gen_start_q <= 1'b1;
                    end
                end
                StStart: begin
                    state_q <= StStream;
                    hdr_q   <= buf_word;
                end
                StStream: begin
                    if (host_stop_i || found_i) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (buf_cnt == '0) begin
                        state_q <= StRun;
                        hdr_q   <= '0;
                    end else begin
                        hdr_q <= buf_word;
                    end
                end
                StRun: begin
                    if (abort_pend_q || host_stop_i || found_i) begin
                        state_q       <= StStop;
                        gen_stop_q    <= 1'b1;
                        job_aborted_q <= 1'b1;
                    end else if (all_ack) begin
                        state_q     <= StDone;
                        job_done_q  <= 1'b1;
                        job_count_q <= job_count_q + 32'd1;
                    end
                end
                StStop: begin
                    // Held as a level: generators only look at stop between frames.
                    if (all_ack) begin
                        state_q     <= StDone;
                        gen_stop_q  <= 1'b0;
                        job_done_q  <= 1'b1;
                        job_count_q <= job_count_q + 32'd1;
                    end
                end
                StDone: begin
                    state_q      <= StIdle;
                    busy_q       <= 1'b0;
                    abort_pend_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bh_fifo_re_o       = buf_shift;
    assign gen_start_o        = gen_start_q;
    assign gen_stop_o         = gen_stop_q;
    assign gen_block_header_o = hdr_q;
    assign gen_nonce_size_o   = nonce_q;
    assign busy_o             = busy_q;
    assign job_done_o         = job_done_q;
    assign job_aborted_o      = job_aborted_q;
    assign job_count_o        = job_count_q;

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Self-checking bench for miner_job_ctrl: a FIFO model feeds headers, streamed words
// are checked against a scoreboard queue filled when the headers are written.
module tb_miner_job_ctrl;

    localparam int unsigned NUM_GEN = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               host_start;
    logic               host_stop;
    logic [31:0]        nonce_size_in;
    logic               found;
    logic [31:0]        bh_fifo_dout;
    logic               bh_fifo_empty;
    logic               bh_fifo_re;
    logic               gen_start;
    logic               gen_stop;
    logic [31:0]        gen_block_header;
    logic [31:0]        gen_nonce_size;
    logic [NUM_GEN-1:0] gen_stop_ack;
    logic               busy;
    logic               job_done;
    logic               job_aborted;
    logic [31:0]        job_count;

    always #5 clk = ~clk;

    // FWFT FIFO model
    logic [31:0] fifo_mem [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        stall;

    assign bh_fifo_empty = stall || (rd_ptr == wr_ptr);
    assign bh_fifo_dout  = fifo_mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (bh_fifo_re && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
    end

    logic [31:0] sb_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_count;

    miner_job_ctrl #(.NUM_GEN(NUM_GEN)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .host_start_i       (host_start),
        .host_stop_i        (host_stop),
        .nonce_size_in_i    (nonce_size_in),
        .found_i            (found),
        .bh_fifo_dout_i     (bh_fifo_dout),
        .bh_fifo_empty_i    (bh_fifo_empty),
        .bh_fifo_re_o       (bh_fifo_re),
        .gen_start_o        (gen_start),
        .gen_stop_o         (gen_stop),
        .gen_block_header_o (gen_block_header),
        .gen_nonce_size_o   (gen_nonce_size),
        .gen_stop_ack_i     (gen_stop_ack),
        .busy_o             (busy),
        .job_done_o         (job_done),
        .job_aborted_o      (job_aborted),
        .job_count_o        (job_count)
    );

    task automatic push_header(input logic [31:0] base, input bit rnd, input bit to_sb);
        logic [31:0] w;
        for (int k = 0; k < 20; k++) begin
            w = rnd ? $urandom : base + 32'(k);
            fifo_mem[wr_ptr[7:0]] = w;
            wr_ptr = wr_ptr + 1;
            if (to_sb) sb_q.push_back(w);
        end
    endtask

    task automatic pulse_start(input logic [31:0] nsize);
        @(negedge clk);
        host_start    = 1'b1;
        nonce_size_in = nsize;
        @(negedge clk);
        host_start = 1'b0;
    endtask

    // Waits for gen_start, then checks the 20 streamed words against the scoreboard.
    task automatic check_dispatch(input string tag, input bit drop_ack);
        logic [31:0] exp;
        int          t = 0;
        while (gen_start !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (gen_start !== 1'b1) begin
            n_err++;
            $display("FAIL %s_start: gen_start=%b required 1", tag, gen_start);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (drop_ack && k == 0) gen_stop_ack = '0;
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
            n_cmp++;
            if (gen_block_header !== exp || gen_start !== 1'b0) begin
                n_err++;
                $display("FAIL %s_word%0d: header=%h start=%b required header=%h start=0",
                         tag, k, gen_block_header, gen_start, exp);
            end
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_ab);
        int t = 0;
        while (job_done !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        exp_count = exp_count + 32'd1;
        n_cmp++;
        if (job_done !== 1'b1 || job_aborted !== exp_ab || job_count !== exp_count) begin
            n_err++;
            $display("FAIL %s_done: done=%b aborted=%b count=%h required 1 %b %h",
                     tag, job_done, job_aborted, job_count, exp_ab, exp_count);
        end
        @(negedge clk);
        n_cmp++;
        if (job_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: done=%b busy=%b required 0 0", tag, job_done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bh_fifo_re, gen_start, gen_stop, busy, job_done, job_aborted} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: %b required 000000",
                     {bh_fifo_re, gen_start, gen_stop, busy, job_done, job_aborted});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (gen_block_header !== 32'd0 || gen_nonce_size !== 32'd0 || job_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_words: hdr=%h nonce=%h count=%h required 0",
                     gen_block_header, gen_nonce_size, job_count);
        end
        exp_count = 32'd0;
    endtask

    task automatic test_basic();
        push_header(32'd1, 1'b0, 1'b1);
        pulse_start(32'd0);
        n_cmp++;
        if (busy !== 1'b1 || gen_nonce_size !== 32'd0) begin
            n_err++;
            $display("FAIL basic_busy: busy=%b nonce=%h required 1 0", busy, gen_nonce_size);
        end
        check_dispatch("basic", 1'b0);
        wait_done("basic", 1'b0);
    endtask

    task automatic test_fifo_stall();
        int unsigned base = rd_ptr;
        int          t = 0;
        push_header(32'd1, 1'b0, 1'b1);
        pulse_start(32'h0000_1234);
        while (rd_ptr != base + 8 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (bh_fifo_re !== 1'b1 || gen_nonce_size !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL stall_pre: re=%b nonce=%h required 1 00001234", bh_fifo_re, gen_nonce_size);
        end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bh_fifo_re !== 1'b0 || rd_ptr != base + 8) begin
                n_err++;
                $display("FAIL stall_re%0d: re=%b words=%0d required 0 8", i, bh_fifo_re, rd_ptr - base);
            end
        end
        stall = 1'b0;
        check_dispatch("stall", 1'b0);
        wait_done("stall", 1'b0);
    endtask

    task automatic test_found();
        int high = 0;
        push_header(32'd0, 1'b1, 1'b1);
        pulse_start(32'h0100_0000);
        check_dispatch("found", 1'b1);
        repeat (100) @(negedge clk);
        n_cmp++;
        if (gen_stop !== 1'b0 || busy !== 1'b1 || job_done !== 1'b0) begin
            n_err++;
            $display("FAIL found_run: stop=%b busy=%b done=%b required 0 1 0", gen_stop, busy, job_done);
        end
        found = 1'b1;
        @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (gen_stop !== 1'b1) break;
            high++;
            if (high == 10) gen_stop_ack = '1;
            @(negedge clk);
        end
        n_cmp++;
        if (high != 10) begin
            n_err++;
            $display("FAIL found_stop_len: gen_stop high %0d cycles required 10", high);
        end
        wait_done("found", 1'b1);
    endtask

    task automatic test_stop_load();
        int unsigned base = rd_ptr;
        int          t = 0;
        int          starts = 0;
        push_header(32'hA000_0000, 1'b0, 1'b0);
        pulse_start(32'd7);
        while (rd_ptr != base + 4 && t < 50) begin
            @(negedge clk);
            t++;
        end
        host_stop = 1'b1;
        @(negedge clk);
        host_stop = 1'b0;
        t = 0;
        while (job_done !== 1'b1 && t < 100) begin
            if (gen_start === 1'b1) starts++;
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (starts != 0 || rd_ptr != base + 20) begin
            n_err++;
            $display("FAIL stopload_drain: starts=%0d words=%0d required 0 20", starts, rd_ptr - base);
        end
        wait_done("stopload", 1'b1);
        push_header(32'hB000_0000, 1'b0, 1'b1);
        pulse_start(32'd9);
        check_dispatch("second", 1'b0);
        wait_done("second", 1'b0);
    endtask

    task automatic test_busy_reset();
        int unsigned base = rd_ptr;
        int          t = 0;
        push_header(32'd0, 1'b1, 1'b1);
        pulse_start(32'd3);
        repeat (3) @(negedge clk);
        pulse_start(32'hFFFF_0000);
        n_cmp++;
        if (gen_nonce_size !== 32'd3) begin
            n_err++;
            $display("FAIL busy_nonce: nonce=%h required 00000003", gen_nonce_size);
        end
        check_dispatch("busy", 1'b0);
        wait_done("busy", 1'b0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rd_ptr != base + 20) begin
            n_err++;
            $display("FAIL busy_ignored: busy=%b words=%0d required 0 20", busy, rd_ptr - base);
        end
        push_header(32'd0, 1'b1, 1'b1);
        pulse_start(32'h0000_ABCD);
        while (gen_start !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (gen_start !== 1'b0 || gen_stop !== 1'b0 || gen_block_header !== 32'd0 ||
            busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_async: start=%b stop=%b hdr=%h busy=%b required 0",
                     gen_start, gen_stop, gen_block_header, busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({bh_fifo_re, job_done, job_aborted} !== 3'b0 || gen_nonce_size !== 32'd0 ||
            job_count !== 32'd0) begin
            n_err++;
            $display("FAIL rst_state: flags=%b nonce=%h count=%h required 0",
                     {bh_fifo_re, job_done, job_aborted}, gen_nonce_size, job_count);
        end
        rst_n = 1'b1;
        sb_q.delete();
        exp_count = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        force dut.job_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.job_count_q;
        exp_count = 32'hFFFF_FFFF;
        push_header(32'h5A00_0000, 1'b0, 1'b1);
        pulse_start(32'd1);
        check_dispatch("wrap", 1'b0);
        wait_done("wrap", 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        host_start    = 1'b0;
        host_stop     = 1'b0;
        found         = 1'b0;
        nonce_size_in = '0;
        gen_stop_ack  = '1;
        stall         = 1'b0;
        exp_count     = '0;
        test_reset();
        test_basic();
        test_fifo_stall();
        test_found();
        test_stop_load();
        test_busy_reset();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
